// File: rtl/kpscan.sv
// kpscan: column scanner, row synchroniser and debouncer for a 4x4 matrix keypad.
// Drives one-hot-low column strobes, samples the active-low rows through a
// two-flop synchroniser and locks onto a single debounced key. The locked
// column (kpc) and row code (kpr_q) feed the downstream key decoder.
//
// Build option:
//   KPSCAN_REPEAT_EN - when defined, kp_press also pulses every REPEAT_CYCLES
//                      clocks while a key stays held. When undefined no repeat
//                      logic exists and each accepted press gives one pulse.
module kpscan #(
    parameter int SCAN_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic [3:0] kpr_q,
    output logic       kphit,
    output logic       kp_press
);

    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    // A pulse period below two clocks would merge repeat pulses into a level.
    if (SCAN_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("kpscan: SCAN_CYCLES and DEBOUNCE_CYCLES must be >= 1, REPEAT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        ST_SCAN        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } state_t;

    // A usable row code has exactly one row pulled low.
    function automatic logic row_valid(input logic [3:0] row);
        logic [3:0] low;
        low = ~row;
        return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
    endfunction

    // Next column strobe: 0111 -> 1011 -> 1101 -> 1110 -> 0111.
    function automatic logic [3:0] col_rotate(input logic [3:0] col);
        return {col[0], col[3:1]};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        kpr_meta_r;
    logic [3:0]        kpr_s_r;
    logic [3:0]        row_cap_r;
    logic [3:0]        row_cap_nxt_s;
    logic [SCAN_W-1:0] dwell_r;
    logic [SCAN_W-1:0] dwell_nxt_s;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [DEB_W-1:0]  deb_cnt_nxt_s;
    logic [3:0]        kpc_r;
    logic [3:0]        kpc_nxt_s;
    logic [3:0]        kpr_q_r;
    logic [3:0]        kpr_q_nxt_s;
    logic              kphit_r;
    logic              kphit_nxt_s;
    logic              kp_press_r;
    logic              kp_press_nxt_s;
    logic              row_ok_s;
    logic              row_idle_s;
    logic              row_same_s;

`ifdef KPSCAN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0]  rep_cnt_r;
    logic [REP_W-1:0]  rep_cnt_nxt_s;
`endif

    assign row_ok_s   = row_valid(kpr_s_r);
    assign row_idle_s = (kpr_s_r == 4'hF);
    assign row_same_s = (kpr_s_r == row_cap_r);

    // Two-flop synchroniser for the asynchronous row inputs (idle rows read high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kpr_meta_r <= 4'hF;
            kpr_s_r    <= 4'hF;
        end else begin
            kpr_meta_r <= kpr;
            kpr_s_r    <= kpr_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SCAN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SCAN: begin
                if (dwell_r == SCAN_LAST && row_ok_s) begin
                    state_nxt_s = ST_DEB_PRESS;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DEB_PRESS: begin
                if (!row_same_s) begin
                    state_nxt_s = ST_SCAN;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = ST_PRESSED;
                end else begin
                    state_nxt_s = ST_DEB_PRESS;
                end
            end
            ST_PRESSED: begin
                if (row_idle_s) begin
                    state_nxt_s = ST_DEB_RELEASE;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_DEB_RELEASE: begin
                if (!row_idle_s) begin
                    state_nxt_s = ST_PRESSED;
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_DEB_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_SCAN;
            end
        endcase
    end

    // FSM output/datapath decode: next values of counters, capture and outputs.
    always_comb begin
        kpc_nxt_s      = kpc_r;
        kpr_q_nxt_s    = kpr_q_r;
        kphit_nxt_s    = kphit_r;
        kp_press_nxt_s = 1'b0;
        row_cap_nxt_s  = row_cap_r;
        dwell_nxt_s    = dwell_r;
        deb_cnt_nxt_s  = deb_cnt_r;
`ifdef KPSCAN_REPEAT_EN
        rep_cnt_nxt_s  = rep_cnt_r;
`endif
        case (state_r)
            ST_SCAN: begin
                if (dwell_r == SCAN_LAST) begin
                    dwell_nxt_s = {SCAN_W{1'b0}};
                    if (row_ok_s) begin
                        // Column stays driven so the key can be debounced.
                        row_cap_nxt_s = kpr_s_r;
                        deb_cnt_nxt_s = {DEB_W{1'b0}};
                    end else begin
                        kpc_nxt_s = col_rotate(kpc_r);
                    end
                end else begin
                    dwell_nxt_s = dwell_r + SCAN_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (!row_same_s) begin
                    kpc_nxt_s     = col_rotate(kpc_r);
                    dwell_nxt_s   = {SCAN_W{1'b0}};
                    deb_cnt_nxt_s = {DEB_W{1'b0}};
                end else if (deb_cnt_r == DEB_LAST) begin
                    kphit_nxt_s    = 1'b1;
                    kpr_q_nxt_s    = row_cap_r;
                    kp_press_nxt_s = 1'b1;
                    deb_cnt_nxt_s  = {DEB_W{1'b0}};
`ifdef KPSCAN_REPEAT_EN
                    rep_cnt_nxt_s  = {REP_W{1'b0}};
`endif
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            ST_PRESSED: begin
                if (row_idle_s) begin
                    deb_cnt_nxt_s = {DEB_W{1'b0}};
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r;
                end
`ifdef KPSCAN_REPEAT_EN
                if (rep_cnt_r == REP_LAST) begin
                    kp_press_nxt_s = 1'b1;
                    rep_cnt_nxt_s  = {REP_W{1'b0}};
                end else begin
                    rep_cnt_nxt_s  = rep_cnt_r + REP_W'(1);
                end
`endif
            end
            ST_DEB_RELEASE: begin
                if (!row_idle_s) begin
                    deb_cnt_nxt_s = {DEB_W{1'b0}};
                end else if (deb_cnt_r == DEB_LAST) begin
                    kphit_nxt_s   = 1'b0;
                    kpr_q_nxt_s   = 4'hF;
                    kpc_nxt_s     = col_rotate(kpc_r);
                    dwell_nxt_s   = {SCAN_W{1'b0}};
                    deb_cnt_nxt_s = {DEB_W{1'b0}};
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DEB_W'(1);
                end
            end
            default: begin
                kpc_nxt_s     = 4'b0111;
                kpr_q_nxt_s   = 4'hF;
                kphit_nxt_s   = 1'b0;
                dwell_nxt_s   = {SCAN_W{1'b0}};
                deb_cnt_nxt_s = {DEB_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kpc_r      <= 4'b0111;
            kpr_q_r    <= 4'hF;
            kphit_r    <= 1'b0;
            kp_press_r <= 1'b0;
            row_cap_r  <= 4'hF;
            dwell_r    <= {SCAN_W{1'b0}};
            deb_cnt_r  <= {DEB_W{1'b0}};
        end else begin
            kpc_r      <= kpc_nxt_s;
            kpr_q_r    <= kpr_q_nxt_s;
            kphit_r    <= kphit_nxt_s;
            kp_press_r <= kp_press_nxt_s;
            row_cap_r  <= row_cap_nxt_s;
            dwell_r    <= dwell_nxt_s;
            deb_cnt_r  <= deb_cnt_nxt_s;
        end
    end

`ifdef KPSCAN_REPEAT_EN
    // Auto-repeat counter; advances only while the key is held in PRESSED.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt_r <= {REP_W{1'b0}};
        end else begin
            rep_cnt_r <= rep_cnt_nxt_s;
        end
    end
`endif

    assign kpc      = kpc_r;
    assign kpr_q    = kpr_q_r;
    assign kphit    = kphit_r;
    assign kp_press = kp_press_r;

endmodule
